// File: rtl/master_output_pkg.sv
// Shared definitions for the master output sequencer: FSM encoding,
// activation-mode encodings, default geometry and a width helper.
package master_output_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Activation modes; 1x is reserved and behaves like ACT_NONE.
  localparam logic [1:0] ACT_NONE = 2'b00;
  localparam logic [1:0] ACT_RELU = 2'b01;

  // Default geometry and the widths derived from it.
  localparam int DEF_SYS_ARR_ROWS = 16;
  localparam int DEF_SYS_ARR_COLS = 16;
  localparam int DEF_MAX_OUT_ROWS = 128;
  localparam int DEF_MAX_OUT_COLS = 128;
  localparam int DEF_ADDR_WIDTH   = 8;

  // Counter width for a count of n items; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NSM = DEF_MAX_OUT_ROWS / DEF_SYS_ARR_ROWS;
  localparam int DEF_NSN = DEF_MAX_OUT_COLS / DEF_SYS_ARR_COLS;
  localparam int DEF_RW  = width_of(DEF_SYS_ARR_ROWS);
  localparam int DEF_CW  = width_of(DEF_SYS_ARR_COLS);

endpackage

// File: rtl/output_addr_gen.sv
// Write-address generator: keeps a registered tile base address that is
// advanced by the stride once per completed tile, and adds the row offset.
module output_addr_gen #(
  parameter int ADDR_WIDTH = 8,
  parameter int RW         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic                  advance,
  input  logic [RW-1:0]         row_num,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [ADDR_WIDTH-1:0] tile_base_q;
  logic [ADDR_WIDTH-1:0] stride_q;

  // Tile base: loaded at job start, bumped by the latched stride per tile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_base_q <= '0;
      stride_q    <= '0;
    end else if (load) begin
      tile_base_q <= base_addr;
      stride_q    <= stride;
    end else if (advance) begin
      tile_base_q <= tile_base_q + stride_q;
    end
  end

  // Row offset on top of the tile base; wraps modulo 2^ADDR_WIDTH.
  always_comb begin
    addr = tile_base_q + ADDR_WIDTH'(row_num);
  end

endmodule

// File: rtl/master_output_sequencer.sv
// Master output sequencer: walks tiles in row-major order and issues one
// output row per accepted cycle to the output memory.
// Handshake: a row is transferred in any WRITE cycle where wr_ready=1; the
// sequencer presents wr_en/wr_addr combinationally in that same cycle and
// holds every counter when wr_ready=0.
module master_output_sequencer
  import master_output_pkg::*;
#(
  parameter int SYS_ARR_ROWS = DEF_SYS_ARR_ROWS,
  parameter int SYS_ARR_COLS = DEF_SYS_ARR_COLS,
  parameter int MAX_OUT_ROWS = DEF_MAX_OUT_ROWS,
  parameter int MAX_OUT_COLS = DEF_MAX_OUT_COLS,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  localparam int NSM = MAX_OUT_ROWS / SYS_ARR_ROWS,
  localparam int NSN = MAX_OUT_COLS / SYS_ARR_COLS,
  localparam int MW  = width_of(NSM),
  localparam int NW  = width_of(NSN),
  localparam int RW  = width_of(SYS_ARR_ROWS),
  localparam int CW  = width_of(SYS_ARR_COLS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [MW-1:0]                      num_submats_m,
  input  logic [NW-1:0]                      num_submats_n,
  input  logic [RW-1:0]                      num_rows_read,
  input  logic [CW-1:0]                      num_cols_read,
  input  logic [1:0]                         act_mode,
  input  logic                               clear_after,
  input  logic [ADDR_WIDTH-1:0]              wr_base_addr,
  input  logic [ADDR_WIDTH-1:0]              wr_stride,
  input  logic                               wr_ready,
  output logic                               busy,
  output logic                               done,
  output logic [MW-1:0]                      submat_row_out,
  output logic [NW-1:0]                      submat_col_out,
  output logic [RW-1:0]                      row_num,
  output logic                               relu_en,
  output logic                               accum_reset,
  output logic [SYS_ARR_COLS-1:0]            wr_en,
  output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] wr_addr,
  output logic [1:0]                         state_dbg
);

  state_t state_q, state_d;

  logic [MW-1:0] cfg_m, sm_row_q;
  logic [NW-1:0] cfg_n, sm_col_q;
  logic [RW-1:0] cfg_rows, row_q;
  logic [CW-1:0] cfg_cols;
  logic          cfg_relu, cfg_clear;

  logic                    start_ok, issue, last_row, last_tile, tile_done;
  logic [SYS_ARR_COLS-1:0] col_mask;
  logic [ADDR_WIDTH-1:0]   row_addr;

  assign start_ok  = (state_q == ST_IDLE) && start;
  assign issue     = (state_q == ST_WRITE) && wr_ready;
  assign last_row  = (row_q == cfg_rows);
  assign last_tile = (sm_row_q == cfg_m) && (sm_col_q == cfg_n);
  assign tile_done = issue && last_row;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle control outputs.
  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    wr_en       = '0;
    relu_en     = 1'b0;
    accum_reset = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        busy = 1'b1;
        if (wr_ready) begin
          wr_en       = col_mask;
          relu_en     = cfg_relu;
          accum_reset = cfg_clear && last_row;
          if (last_row && last_tile) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Column enable mask: the low (num_cols_read+1) lanes are active.
  always_comb begin
    col_mask = '0;
    for (int i = 0; i < SYS_ARR_COLS; i++) begin
      col_mask[i] = (i <= int'(cfg_cols));
    end
  end

  // Job configuration, captured only when a start is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_m     <= '0;
      cfg_n     <= '0;
      cfg_rows  <= '0;
      cfg_cols  <= '0;
      cfg_relu  <= 1'b0;
      cfg_clear <= 1'b0;
    end else if (start_ok) begin
      cfg_m     <= num_submats_m;
      cfg_n     <= num_submats_n;
      cfg_rows  <= num_rows_read;
      cfg_cols  <= num_cols_read;
      cfg_relu  <= (act_mode == ACT_RELU);
      cfg_clear <= clear_after;
    end
  end

  // Row and tile counters; tile column advances first, then tile row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q    <= '0;
      sm_row_q <= '0;
      sm_col_q <= '0;
    end else if (start_ok) begin
      row_q    <= '0;
      sm_row_q <= '0;
      sm_col_q <= '0;
    end else if (issue) begin
      if (last_row) begin
        row_q <= '0;
        if (!last_tile) begin
          if (sm_col_q == cfg_n) begin
            sm_col_q <= '0;
            sm_row_q <= sm_row_q + MW'(1);
          end else begin
            sm_col_q <= sm_col_q + NW'(1);
          end
        end
      end else begin
        row_q <= row_q + RW'(1);
      end
    end
  end

  output_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RW         (RW)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (start_ok),
    .base_addr (wr_base_addr),
    .stride    (wr_stride),
    .advance   (tile_done && !last_tile),
    .row_num   (row_q),
    .addr      (row_addr)
  );

  assign wr_addr        = {SYS_ARR_COLS{row_addr}};
  assign submat_row_out = sm_row_q;
  assign submat_col_out = sm_col_q;
  assign row_num        = row_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_master_output_sequencer.sv
// Bench for master_output_sequencer: a reference model fills an expected
// queue per job, a negedge monitor pops and compares every issued row.
module tb_master_output_sequencer;

  localparam int AW   = 8;
  localparam int COLS = 16;
  localparam int MW   = 3;
  localparam int NW   = 3;
  localparam int RW   = 4;
  localparam int CW   = 4;
  localparam int W    = AW + COLS + 2 + MW + NW + RW;

  logic                 clk, reset, start;
  logic [MW-1:0]        num_submats_m;
  logic [NW-1:0]        num_submats_n;
  logic [RW-1:0]        num_rows_read;
  logic [CW-1:0]        num_cols_read;
  logic [1:0]           act_mode;
  logic                 clear_after;
  logic [AW-1:0]        wr_base_addr, wr_stride;
  logic                 wr_ready;
  logic                 busy, done, relu_en, accum_reset;
  logic [MW-1:0]        submat_row_out;
  logic [NW-1:0]        submat_col_out;
  logic [RW-1:0]        row_num;
  logic [COLS-1:0]      wr_en;
  logic [COLS*AW-1:0]   wr_addr;
  logic [1:0]           state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  master_output_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .num_submats_m(num_submats_m), .num_submats_n(num_submats_n),
    .num_rows_read(num_rows_read), .num_cols_read(num_cols_read),
    .act_mode(act_mode), .clear_after(clear_after),
    .wr_base_addr(wr_base_addr), .wr_stride(wr_stride), .wr_ready(wr_ready),
    .busy(busy), .done(done),
    .submat_row_out(submat_row_out), .submat_col_out(submat_col_out),
    .row_num(row_num), .relu_en(relu_en), .accum_reset(accum_reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: every row of every tile, in row-major tile order.
  task automatic push_job(input int m, input int n, input int rows, input int cols,
                          input int act, input int clr, input int base, input int stride);
    logic [AW-1:0]   a;
    logic [COLS:0]   mask;
    logic [W-1:0]    e;
    int              t;
    for (int tr = 0; tr <= m; tr++)
      for (int tc = 0; tc <= n; tc++)
        for (int r = 0; r <= rows; r++) begin
          t    = tr * (n + 1) + tc;
          a    = AW'((base + t * stride + r) % 256);
          mask = (17'd1 << (cols + 1)) - 17'd1;
          e    = {a, mask[COLS-1:0], (act == 1), (clr == 1 && r == rows),
                  MW'(tr), NW'(tc), RW'(r)};
          exp_q.push_back(e);
        end
  endtask

  task automatic scramble_cfg();
    num_submats_m = MW'($urandom);
    num_submats_n = NW'($urandom);
    num_rows_read = RW'($urandom);
    num_cols_read = CW'($urandom);
    act_mode      = 2'($urandom);
    clear_after   = 1'($urandom);
    wr_base_addr  = AW'($urandom);
    wr_stride     = AW'($urandom);
  endtask

  // Called at posedge+1 while idle: start a job and drive it to completion.
  // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1,0,0...
  task automatic run_job(input int m, input int n, input int rows, input int cols,
                         input int act, input int clr, input int base, input int stride,
                         input int mode);
    int total, acc, k;
    logic rdy;
    push_job(m, n, rows, cols, act, clr, base, stride);
    num_submats_m = MW'(m);  num_submats_n = NW'(n);
    num_rows_read = RW'(rows); num_cols_read = CW'(cols);
    act_mode = 2'(act); clear_after = 1'(clr);
    wr_base_addr = AW'(base); wr_stride = AW'(stride);
    start = 1'b1; wr_ready = 1'b0;
    total = (m + 1) * (n + 1) * (rows + 1);
    acc = 0; k = 0;
    while (acc < total) begin
      tick();
      start = ($urandom_range(0, 7) == 0);
      scramble_cfg();
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: rdy = (k % 3 == 0);
      endcase
      wr_ready = rdy;
      k++;
      check("busy_in_write", busy, 1);
      check("no_early_done", done, 0);
      if (rdy) acc++;
    end
    tick();
    start = 1'b1;
    wr_ready = 1'($urandom);
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
    check("wr_en_in_done", wr_en, 0);
    check("relu_acc_in_done", {relu_en, accum_reset}, 0);
    tick();
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("start_in_done_ignored", busy, 0);
    check("all_rows_issued", exp_q.size(), 0);
  endtask

  // Monitor: every issued row must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    logic [W-1:0] got, e;
    if (!reset && wr_en != '0) begin
      got = {wr_addr[AW-1:0], wr_en, relu_en, accum_reset,
             submat_row_out, submat_col_out, row_num};
      if (exp_q.size() == 0) begin
        check("unexpected_write", got, '0);
      end else begin
        e = exp_q.pop_front();
        check("write_row", got, e);
        check("wr_en_needs_ready", wr_ready, 1);
        check("addr_replicated", wr_addr[COLS*AW-1:AW], {(COLS-1){e[W-1:W-AW]}});
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1; start = 1'b0; wr_ready = 1'b0;
    num_submats_m = '0; num_submats_n = '0; num_rows_read = '0; num_cols_read = '0;
    act_mode = '0; clear_after = 1'b0; wr_base_addr = '0; wr_stride = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_state", state_dbg, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_addr", wr_addr, 0);
    reset = 1'b0;
    tick();

    // Single tile, full width, base 0x10.
    run_job(0, 0, 15, 15, 0, 0, 'h10, 0, 0);
    // 2x2 tiles, 4 rows, stride 0x20, clear after each tile.
    run_job(1, 1, 3, 15, 0, 1, 'h00, 'h20, 0);
    // Five columns with ReLU.
    run_job(0, 1, 5, 4, 1, 0, 'h33, 'h08, 0);
    // Stall pattern 1,0,0,1,...
    run_job(1, 0, 3, 7, 0, 1, 'h40, 'h10, 2);
    // Address wrap at 0xFF.
    run_job(0, 0, 3, 15, 0, 0, 'hFE, 0, 0);
    // Reserved activation mode behaves like none.
    run_job(0, 0, 2, 2, 2, 1, 'h05, 0, 1);

    // Abort mid-job with reset, then restart.
    push_job(1, 1, 7, 15, 1, 1, 'h80, 'h10);
    num_submats_m = 1; num_submats_n = 1; num_rows_read = 7; num_cols_read = 15;
    act_mode = 1; clear_after = 1; wr_base_addr = 'h80; wr_stride = 'h10;
    start = 1'b1; wr_ready = 1'b0;
    repeat (11) begin
      tick();
      start = 1'b0;
      wr_ready = 1'b1;
    end
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("abort_busy", busy, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_addr", wr_addr, 0);
    check("abort_counters", {submat_row_out, submat_col_out, row_num}, 0);
    check("abort_relu_acc", {relu_en, accum_reset, done}, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort_no_done", done, 0);
    end
    tick();
    reset = 1'b0;
    run_job(1, 1, 7, 15, 1, 1, 'h80, 'h10, 0);

    // Random jobs with random back-pressure.
    repeat (6) begin
      run_job($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 255), $urandom_range(0, 255), 1);
    end

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
